// File: rtl/fifo_buffer_pkg.sv
// Shared helpers for the single-clock primitive library: constant clog2 and the
// width derivations used by fifo_buffer, its storage and its interface.
package fifo_buffer_pkg;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction

   // A zero-width primitive still exposes a 1-bit bus, tied to 0.
   function automatic int bus_width(input int width);
      return (width < 1) ? 1 : width;
   endfunction

   function automatic int count_width(input int depth);
      return clog2(depth + 1);
   endfunction

   function automatic int ptr_width(input int depth);
      return (clog2(depth) < 1) ? 1 : clog2(depth);
   endfunction

endpackage

// File: rtl/fifo_buffer_if.sv
// Enqueue/dequeue handshake bundle for fifo_buffer; slave is the FIFO side,
// master is the producer/consumer side.
interface fifo_buffer_if #(
   parameter int width = 1,
   parameter int depth = 2
);
   localparam int DW = fifo_buffer_pkg::bus_width(width);
   localparam int CW = fifo_buffer_pkg::count_width(depth);

   logic [DW-1:0] IN_ENQ;
   logic          IN_EN_ENQ;
   logic          OUT_NOT_FULL;
   logic          IN_EN_DEQ;
   logic [DW-1:0] OUT_FIRST;
   logic          OUT_NOT_EMPTY;
   logic          IN_EN_CLEAR;
   logic [CW-1:0] OUT_COUNT;
   logic          OUT_OVERFLOW;
   logic          OUT_UNDERFLOW;

   modport slave (
      input  IN_ENQ, IN_EN_ENQ, IN_EN_DEQ, IN_EN_CLEAR,
      output OUT_NOT_FULL, OUT_FIRST, OUT_NOT_EMPTY, OUT_COUNT,
             OUT_OVERFLOW, OUT_UNDERFLOW
   );

   modport master (
      output IN_ENQ, IN_EN_ENQ, IN_EN_DEQ, IN_EN_CLEAR,
      input  OUT_NOT_FULL, OUT_FIRST, OUT_NOT_EMPTY, OUT_COUNT,
             OUT_OVERFLOW, OUT_UNDERFLOW
   );
endinterface

// File: rtl/fifo_storage.sv
// depth x width register array: one synchronous write port, one asynchronous
// read port. A zero-width instance holds nothing and reads back 0.
module fifo_storage
   import fifo_buffer_pkg::*;
#(
   parameter int width = 1,
   parameter int depth = 2
) (
   input  logic                          clk,
   input  logic                          we,
   input  logic [ptr_width(depth)-1:0]   waddr,
   input  logic [bus_width(width)-1:0]   wdata,
   input  logic [ptr_width(depth)-1:0]   raddr,
   output logic [bus_width(width)-1:0]   rdata
);

   if (width == 0) begin : g_zero
      logic unused;
      assign unused = ^{clk, we, waddr, wdata, raddr};
      assign rdata  = '0;
   end else begin : g_mem
      logic [width-1:0] mem [depth];

      // NOTE: storage is deliberately left without a reset; only pointers and
      // count define which entries are meaningful, so the array can map to RAM.
      always_ff @(posedge clk) begin
         if (we) mem[waddr] <= wdata;
      end

      assign rdata = mem[raddr];
   end

endmodule

// File: rtl/fifo_buffer.sv
// Parameterised synchronous FIFO: pointers, occupancy, sticky misuse flags and
// request acceptance. Data lives in fifo_storage.
module fifo_buffer
   import fifo_buffer_pkg::*;
#(
   parameter int width = 1,
   parameter int depth = 2
) (
   input  logic        CLK,
   input  logic        RST,
   fifo_buffer_if.slave bus
);

   localparam int DW = bus_width(width);
   localparam int CW = count_width(depth);
   localparam int PW = ptr_width(depth);

   localparam logic [CW-1:0] FULL_COUNT = CW'(depth);
   localparam logic [PW-1:0] LAST_PTR   = PW'(depth - 1);

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic          overflow;
   logic          underflow;

   logic          enq_ok;
   logic          deq_ok;
   logic          enq_refused;
   logic          deq_refused;
   logic [DW-1:0] head_data;

   // Depth need not be a power of two, so wrap by compare rather than overflow.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // NOTE: every output of this block gets a default first, so no path through
   // the ifs leaves a signal unassigned and no latch is inferred.
   always_comb begin
      enq_ok      = 1'b0;
      deq_ok      = 1'b0;
      enq_refused = 1'b0;
      deq_refused = 1'b0;
      if (!bus.IN_EN_CLEAR) begin
         enq_ok      = bus.IN_EN_ENQ && (count < FULL_COUNT);
         deq_ok      = bus.IN_EN_DEQ && (count != '0);
         enq_refused = bus.IN_EN_ENQ && !(count < FULL_COUNT);
         deq_refused = bus.IN_EN_DEQ && (count == '0);
      end
   end

   // NOTE: state registers use non-blocking assignments so every register in
   // the design samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (bus.IN_EN_CLEAR) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (enq_ok) tail <= next_ptr(tail);
         if (deq_ok) head <= next_ptr(head);
         case ({enq_ok, deq_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (enq_refused) overflow  <= 1'b1;
         if (deq_refused) underflow <= 1'b1;
      end
   end

   fifo_storage #(
      .width (width),
      .depth (depth)
   ) u_storage (
      .clk   (CLK),
      .we    (enq_ok),
      .waddr (tail),
      .wdata (bus.IN_ENQ),
      .raddr (head),
      .rdata (head_data)
   );

   assign bus.OUT_FIRST     = (count != '0) ? head_data : '0;
   assign bus.OUT_NOT_FULL  = (count < FULL_COUNT);
   assign bus.OUT_NOT_EMPTY = (count != '0);
   assign bus.OUT_COUNT     = count;
   assign bus.OUT_OVERFLOW  = overflow;
   assign bus.OUT_UNDERFLOW = underflow;

endmodule

// File: tb/tb_fifo_buffer.sv
// Three FIFOs (4x8, 3x8, 5x0) share one stimulus stream and are checked against
// queue-based reference models through an expected-output scoreboard.
module tb_fifo_buffer;

   typedef struct packed {
      logic [7:0] first;
      logic       not_full;
      logic       not_empty;
      logic       ovf;
      logic       udf;
      logic [3:0] count;
   } snap_t;

   localparam int NDUT = 3;
   localparam int DEPTHS [NDUT] = '{4, 3, 5};

   logic       clk = 1'b0;
   logic       rst;
   logic       enq;
   logic       deq;
   logic       clr;
   logic [7:0] din;

   int checks = 0;
   int errors = 0;

   int         mq [NDUT][$];
   bit         movf [NDUT];
   bit         mudf [NDUT];
   snap_t [NDUT-1:0] exp_q [$];

   always #5 clk = ~clk;

   fifo_buffer_if #(.width(8), .depth(4)) bus_a ();
   fifo_buffer_if #(.width(8), .depth(3)) bus_b ();
   fifo_buffer_if #(.width(0), .depth(5)) bus_c ();

   assign bus_a.IN_ENQ = din;
   assign bus_b.IN_ENQ = din;
   assign bus_c.IN_ENQ = din[0];
   assign bus_a.IN_EN_ENQ = enq;
   assign bus_b.IN_EN_ENQ = enq;
   assign bus_c.IN_EN_ENQ = enq;
   assign bus_a.IN_EN_DEQ = deq;
   assign bus_b.IN_EN_DEQ = deq;
   assign bus_c.IN_EN_DEQ = deq;
   assign bus_a.IN_EN_CLEAR = clr;
   assign bus_b.IN_EN_CLEAR = clr;
   assign bus_c.IN_EN_CLEAR = clr;

   fifo_buffer #(.width(8), .depth(4)) dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
   fifo_buffer #(.width(8), .depth(3)) dut_b (.CLK(clk), .RST(rst), .bus(bus_b));
   fifo_buffer #(.width(0), .depth(5)) dut_c (.CLK(clk), .RST(rst), .bus(bus_c));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_snap(input string tag, input int i, input snap_t a, input snap_t e);
      check($sformatf("%s[%0d].first", tag, i),     32'(a.first),     32'(e.first));
      check($sformatf("%s[%0d].not_full", tag, i),  32'(a.not_full),  32'(e.not_full));
      check($sformatf("%s[%0d].not_empty", tag, i), 32'(a.not_empty), 32'(e.not_empty));
      check($sformatf("%s[%0d].overflow", tag, i),  32'(a.ovf),       32'(e.ovf));
      check($sformatf("%s[%0d].underflow", tag, i), 32'(a.udf),       32'(e.udf));
      check($sformatf("%s[%0d].count", tag, i),     32'(a.count),     32'(e.count));
   endtask

   function automatic snap_t actual(input int i);
      snap_t s;
      case (i)
         0: s = '{bus_a.OUT_FIRST, bus_a.OUT_NOT_FULL, bus_a.OUT_NOT_EMPTY,
                  bus_a.OUT_OVERFLOW, bus_a.OUT_UNDERFLOW, {1'b0, bus_a.OUT_COUNT}};
         1: s = '{bus_b.OUT_FIRST, bus_b.OUT_NOT_FULL, bus_b.OUT_NOT_EMPTY,
                  bus_b.OUT_OVERFLOW, bus_b.OUT_UNDERFLOW, {2'b0, bus_b.OUT_COUNT}};
         default: s = '{{7'b0, bus_c.OUT_FIRST}, bus_c.OUT_NOT_FULL, bus_c.OUT_NOT_EMPTY,
                  bus_c.OUT_OVERFLOW, bus_c.OUT_UNDERFLOW, {1'b0, bus_c.OUT_COUNT}};
      endcase
      return s;
   endfunction

   function automatic snap_t expected(input int i);
      snap_t s;
      int n;
      n = mq[i].size();
      s.first     = (n > 0) ? 8'(mq[i][0]) : 8'h00;
      s.not_full  = (n < DEPTHS[i]);
      s.not_empty = (n > 0);
      s.ovf       = movf[i];
      s.udf       = mudf[i];
      s.count     = 4'(n);
      return s;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NDUT; i++) begin
         mq[i].delete();
         movf[i] = 1'b0;
         mudf[i] = 1'b0;
      end
   endtask

   // Reference: acceptance is judged on the occupancy before the edge.
   task automatic model_step(input bit e, input bit d, input bit c, input int data);
      int n;
      int v;
      for (int i = 0; i < NDUT; i++) begin
         if (c) begin
            mq[i].delete();
            movf[i] = 1'b0;
            mudf[i] = 1'b0;
         end else begin
            n = mq[i].size();
            if (d) begin
               if (n > 0) v = mq[i].pop_front();
               else mudf[i] = 1'b1;
            end
            if (e) begin
               if (n < DEPTHS[i]) mq[i].push_back((i == 2) ? (data & 1 & 0) : data);
               else movf[i] = 1'b1;
            end
         end
      end
   endtask

   task automatic cycle(input bit e, input bit d, input bit c, input logic [7:0] data);
      snap_t [NDUT-1:0] s;
      enq = e;
      deq = d;
      clr = c;
      din = data;
      @(posedge clk);
      model_step(e, d, c, int'(data));
      for (int i = 0; i < NDUT; i++) s[i] = expected(i);
      exp_q.push_back(s);
      #1;
      enq = 1'b0;
      deq = 1'b0;
      clr = 1'b0;
      din = 8'h00;
   endtask

   task automatic check_direct(input string tag);
      for (int i = 0; i < NDUT; i++) check_snap(tag, i, actual(i), expected(i));
   endtask

   // Monitor: whenever an expected snapshot is pending, compare the settled outputs.
   always @(negedge clk) begin
      snap_t [NDUT-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         for (int i = 0; i < NDUT; i++) check_snap("sb", i, actual(i), e[i]);
      end
   end

   initial begin
      rst = 1'b1;
      enq = 1'b0;
      deq = 1'b0;
      clr = 1'b0;
      din = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_direct("in_reset");
      rst = 1'b0;

      // Idle after release keeps reset values.
      cycle(0, 0, 0, 8'h00);

      // Fill past capacity, then drain past empty.
      cycle(1, 0, 0, 8'h11);
      cycle(1, 0, 0, 8'h22);
      cycle(1, 0, 0, 8'h33);
      cycle(1, 0, 0, 8'h44);
      cycle(1, 0, 0, 8'h55);
      repeat (5) cycle(0, 1, 0, 8'h00);
      cycle(0, 0, 1, 8'h00);

      // Interleaved wrap-around with data 1..10.
      cycle(1, 0, 0, 8'd1);
      for (int k = 2; k <= 10; k++) cycle(1, 1, 0, 8'(k));
      cycle(0, 1, 0, 8'h00);
      cycle(0, 0, 1, 8'h00);

      // Full with enqueue and dequeue together.
      for (int k = 0; k < 4; k++) cycle(1, 0, 0, 8'(8'hA0 + k));
      cycle(1, 1, 0, 8'h99);
      cycle(0, 0, 1, 8'h00);

      // Empty with enqueue and dequeue together: no bypass.
      cycle(1, 1, 0, 8'h5A);

      // Clear beats enqueue and dequeue, and wipes the flags.
      cycle(1, 0, 0, 8'h66);
      cycle(1, 1, 1, 8'hEE);
      cycle(1, 0, 0, 8'h77);
      cycle(0, 0, 1, 8'h00);

      // Asynchronous reset between edges with data and a raised overflow.
      for (int k = 0; k < 6; k++) cycle(1, 0, 0, 8'(8'hC0 + k));
      cycle(0, 1, 0, 8'h00);
      @(posedge clk);
      #2;
      enq = 1'b1;
      din = 8'hFF;
      rst = 1'b1;
      model_reset();
      #1;
      check_direct("async_rst");
      @(posedge clk);
      #1;
      check_direct("held_rst");
      enq = 1'b0;
      rst = 1'b0;

      // Randomised traffic.
      for (int k = 0; k < 400; k++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 31) == 0), 8'($urandom));
      end

      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_buffer.md
# fifo_buffer

Parameterised synchronous FIFO that joins a write end (enqueue) to a read end (dequeue) in the single-clock primitive library. It sits beside the wire and register primitives and decouples a producer rule from a consumer rule. Valid/enable handshakes use the library's IN_/OUT_ port style. Sticky error flags make misuse visible to the bench.

## Interface
Parameters:
- width, 1, data bits; width 0 is legal and yields a 1-bit bus tied to 0
- depth, 2, number of entries; any integer ≥ 2, not restricted to powers of two

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  reset, asynchronous, active-high
- IN_ENQ  in  width  enqueue data
- IN_EN_ENQ  in  1  enqueue request
- OUT_NOT_FULL  out  1  1 when count < depth
- IN_EN_DEQ  in  1  dequeue request
- OUT_FIRST  out  width  head entry; 0 when empty
- OUT_NOT_EMPTY  out  1  1 when count > 0
- IN_EN_CLEAR  in  1  synchronous flush
- OUT_COUNT  out  clog2(depth+1)  occupancy
- OUT_OVERFLOW  out  1  sticky: enqueue refused
- OUT_UNDERFLOW  out  1  sticky: dequeue refused

## Operation
- State: head pointer, tail pointer, count, storage array, two sticky flags.
- The storage array is not reset. Everything else is reset.
- Pointers advance modulo depth. At depth-1 they wrap to 0 by compare, not by truncation.
- Enqueue acceptance:
  - Accepted iff IN_EN_ENQ and count < depth at the start of the cycle.
  - An accepted enqueue writes storage[tail] and advances tail.
- Dequeue acceptance:
  - Accepted iff IN_EN_DEQ and count > 0 at the start of the cycle.
  - An accepted dequeue advances head.
- Simultaneous requests:
  - Both requests accepted: count is unchanged.
  - Full with both requested: the dequeue is accepted and the enqueue is refused (no pass-through).
  - Empty with both requested: the enqueue is accepted and the dequeue is refused. The data does not bypass to OUT_FIRST.
- Refused requests:
  - A refused enqueue sets OUT_OVERFLOW. Storage and pointers are unchanged.
  - A refused dequeue sets OUT_UNDERFLOW.
  - Both flags hold until reset or clear.
- IN_EN_CLEAR:
  - Has priority over enqueue and dequeue in the same cycle; both are ignored and raise no flags.
  - Zeroes head, tail, count and both flags. Storage contents are irrelevant afterwards.
- Output derivation:
  - OUT_FIRST = storage[head] when count > 0, else 0.
  - OUT_NOT_FULL, OUT_NOT_EMPTY and OUT_COUNT are derived from registered count only. They are never combinational from IN_EN_*.

## Timing
- Reset values: OUT_NOT_FULL=1, OUT_NOT_EMPTY=0, OUT_COUNT=0, OUT_FIRST=0, OUT_OVERFLOW=0, OUT_UNDERFLOW=0.
- Asynchronous reset assertion forces these values immediately, including mid-operation. An enqueue or dequeue in flight at the reset edge is lost.
- Enqueue into an empty FIFO at edge n: OUT_FIRST shows the data and OUT_NOT_EMPTY=1 after edge n, i.e. in cycle n+1. Latency is 1 cycle.
- Dequeue at edge n: the next entry (or 0) is on OUT_FIRST in cycle n+1.
- Flags rise in the cycle after the refused request.
- Throughput is one enqueue plus one dequeue per cycle, sustained, when 0 < count < depth.

## Structure
- Shared package:
  - clog2 function
  - count/pointer width derivation
  - width-0 bus width helper (common to all library primitives)
- Sub-module fifo_storage:
  - depth×width register array
  - one synchronous write port (address, data, enable)
  - one asynchronous read port
  - no reset
- The top level holds pointers, count, flags and the acceptance logic.

## Test plan
- Reset state: reset, then release with no requests → all outputs at reset values; OUT_COUNT=0.
- Fill and drain (depth=4, width=8): enqueue 0x11,0x22,0x33,0x44, then a fifth enqueue 0x55 → OUT_NOT_FULL=0 after the fourth and OUT_OVERFLOW=1 after the fifth. Dequeue 4 times → OUT_FIRST reads 0x11,0x22,0x33,0x44, then 0 with OUT_NOT_EMPTY=0.
- Wrap-around (depth=3):
  - Perform 10 interleaved enqueue/dequeue pairs with data 1..10; data order is preserved.
  - OUT_COUNT stays constant through the simultaneous cycles.
  - No flags are set.
- Boundary simultaneity:
  - Full with enqueue+dequeue → count stays depth-1 after the cycle and OUT_OVERFLOW=1.
  - Empty with enqueue 0x5A + dequeue → OUT_UNDERFLOW=1, count=1, OUT_FIRST=0x5A in the next cycle.
- Clear priority: with 2 entries, assert clear+enqueue+dequeue together → count=0, flags 0, OUT_FIRST=0; the next enqueue 0x77 appears alone.
- Asynchronous reset mid-stream: assert RST between clock edges with 3 entries and OUT_OVERFLOW=1 → outputs return to reset values before the next edge.
